// File: rtl/rv32_writeback.sv
// ---------------------------------------------------------------------------
// rv32_writeback
//
// Purpose:
//   Final stage of the rv32 pipeline. Captures the instruction retiring from
//   MEM, aligns and extends the synchronous data-RAM word for loads, and
//   drives the register-file write port. Writes are suppressed for flushed,
//   x0-targeted and misaligned instructions. The written value is also
//   exposed for decode forwarding, and retired instructions are counted.
//
// Parameters:
//   COUNTER_WIDTH    width of instret_out
//   MISALIGNED_TRAP  1: misaligned loads pulse misaligned_out and do not write
//                    0: address LSBs that would misalign are ignored
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   stall_in           hold the WB register
//   flush_in           capture a bubble instead of the MEM instruction
//   valid_in           MEM stage holds a real instruction
//   rd_in              destination register
//   rd_write_in        instruction writes rd
//   mem_read_in        instruction is a load
//   mem_width_in       00 byte, 01 half, 10/11 word
//   mem_unsigned_in    zero-extend loaded byte/half
//   addr_lo_in         load address bits [1:0]
//   result_in          ALU/CSR result for non-loads
//   mem_data_in        raw RAM word, valid in the first WB cycle of a load
//   rd_out             regfile write address
//   rd_write_out       regfile write enable, one pulse per instruction
//   rd_value_out       regfile write data / forwarding value
//   misaligned_out     one-cycle pulse when a misaligned load retires
//   instret_out        retired-instruction counter
// ---------------------------------------------------------------------------
module rv32_writeback #(
    parameter int COUNTER_WIDTH   = 64,
    parameter int MISALIGNED_TRAP = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall_in,
    input  logic                     flush_in,
    input  logic                     valid_in,
    input  logic [4:0]               rd_in,
    input  logic                     rd_write_in,
    input  logic                     mem_read_in,
    input  logic [1:0]               mem_width_in,
    input  logic                     mem_unsigned_in,
    input  logic [1:0]               addr_lo_in,
    input  logic [31:0]              result_in,
    input  logic [31:0]              mem_data_in,
    output logic [4:0]               rd_out,
    output logic                     rd_write_out,
    output logic [31:0]              rd_value_out,
    output logic                     misaligned_out,
    output logic [COUNTER_WIDTH-1:0] instret_out
);

    // Latched instruction fields
    logic                     valid_q;
    logic [4:0]               rd_q;
    logic                     rd_write_q;
    logic                     mem_read_q;
    logic [1:0]               width_q;
    logic                     unsigned_q;
    logic [1:0]               addr_lo_q;
    logic [31:0]              result_q;

    // fresh_q marks the first cycle an instruction sits in WB. The RAM word is
    // only valid then, so the computed value is parked in hold_q for the
    // stalled cycles that follow.
    logic                     fresh_q;
    logic [31:0]              hold_q;
    logic [COUNTER_WIDTH-1:0] instret_q;

    logic [7:0]               byte_sel;
    logic [15:0]              half_sel;
    logic [31:0]              aligned;
    logic                     mis_raw;
    logic                     mis;
    logic [31:0]              value_now;

    // Load alignment and extension, plus the raw misalignment condition
    always_comb begin
        byte_sel = mem_data_in[7:0];
        case (addr_lo_q)
            2'd0: byte_sel = mem_data_in[7:0];
            2'd1: byte_sel = mem_data_in[15:8];
            2'd2: byte_sel = mem_data_in[23:16];
            2'd3: byte_sel = mem_data_in[31:24];
            default: byte_sel = mem_data_in[7:0];
        endcase
        half_sel = addr_lo_q[1] ? mem_data_in[31:16] : mem_data_in[15:0];
        aligned  = mem_data_in;
        mis_raw  = 1'b0;
        case (width_q)
            2'b00: begin
                aligned = {{24{byte_sel[7] & ~unsigned_q}}, byte_sel};
                mis_raw = 1'b0;
            end
            2'b01: begin
                aligned = {{16{half_sel[15] & ~unsigned_q}}, half_sel};
                mis_raw = addr_lo_q[0];
            end
            default: begin
                aligned = mem_data_in;
                mis_raw = (addr_lo_q != 2'b00);
            end
        endcase
    end

    // Misalignment only matters for loads, and only when trapping is enabled
    assign mis       = (MISALIGNED_TRAP != 0) && mem_read_q && mis_raw;
    assign value_now = mem_read_q ? aligned : result_q;

    // WB register: capture on unstalled edges, hold on stalled ones
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            rd_q       <= 5'd0;
            rd_write_q <= 1'b0;
            mem_read_q <= 1'b0;
            width_q    <= 2'b00;
            unsigned_q <= 1'b0;
            addr_lo_q  <= 2'b00;
            result_q   <= 32'd0;
            fresh_q    <= 1'b0;
            hold_q     <= 32'd0;
            instret_q  <= '0;
        end else begin
            if (!stall_in) begin
                valid_q    <= valid_in && !flush_in;
                rd_q       <= rd_in;
                rd_write_q <= rd_write_in;
                mem_read_q <= mem_read_in;
                width_q    <= mem_width_in;
                unsigned_q <= mem_unsigned_in;
                addr_lo_q  <= addr_lo_in;
                result_q   <= result_in;
                fresh_q    <= 1'b1;
            end else begin
                fresh_q    <= 1'b0;
            end
            if (fresh_q) begin
                hold_q <= value_now;
            end
            // Count on the edge that closes an instruction's fresh cycle
            if (fresh_q && valid_q && !mis) begin
                instret_q <= instret_q + COUNTER_WIDTH'(1);
            end
        end
    end

    assign rd_out         = rd_q;
    assign rd_value_out   = fresh_q ? value_now : hold_q;
    assign rd_write_out   = fresh_q && valid_q && rd_write_q && (rd_q != 5'd0) && !mis;
    assign misaligned_out = fresh_q && valid_q && mem_read_q && mis;
    assign instret_out    = instret_q;

endmodule
